// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types, constants and lane-merge helper for the simple-dual-port byte-enabled RAM
package bram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // One byte lane of a byte-enabled merge; callers iterate over the lanes of their own width.
  function automatic logic [7:0] merge_be(input logic [7:0] old_b, input logic [7:0] new_b,
                                          input logic we);
    return we ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - RD_LAT-deep read data/valid pipeline with synchronous clear
module bram_rd_pipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          vld
);

  logic [DW-1:0]     dat [RD_LAT];
  logic [RD_LAT-1:0] val;

  // Data stages only load behind a valid, so the output holds its last word between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      val[0] <= en;
      if (en) dat[0] <= d;
      for (int i = 1; i < RD_LAT; i++) begin
        val[i] <= val[i-1];
        if (val[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign q   = dat[RD_LAT-1];
  assign vld = val[RD_LAT-1];

endmodule

// File: rtl/bram_sdp_be.sv
// rtl/bram_sdp_be.sv - simple-dual-port byte-enabled block RAM with zero-fill sweep after reset
// Optional sticky collision flag port COLL when BRAM_COLLISION_FLAG_EN is defined.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int DW         = 32,
  parameter int WL         = 1024,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int CLR_ON_RST = 1,
  localparam int NB        = DW / 8,
  localparam int AW        = $clog2(WL * NB)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN_W,
  input  logic [NB-1:0] WE,
  input  logic [AW-1:0] A_W,
  input  logic [DW-1:0] Di,
  input  logic          EN_R,
  input  logic [AW-1:0] A_R,
  output logic [DW-1:0] Do,
  output logic          DoVld,
  output logic          BUSY
`ifdef BRAM_COLLISION_FLAG_EN
  ,
  output logic          COLL
`endif
);

  localparam int BW  = $clog2(NB);
  localparam int WAW = $clog2(WL);

  if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
    $error("bram_sdp_be: DW must be a positive multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_sdp_be: RD_LAT must be 1 or 2");
  end
  if (WL < 2 || (WL & (WL - 1)) != 0) begin : g_bad_wl
    $error("bram_sdp_be: WL must be a power of two >= 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("bram_sdp_be: RDW_MODE must be 0 or 1");
  end

  state_t         state;
  logic [WAW-1:0] cnt;
  logic [WAW-1:0] wa;
  logic [WAW-1:0] ra;
  logic [WAW-1:0] mem_wa;
  logic [NB-1:0]  lane_we;
  logic [DW-1:0]  wr_data;
  logic [DW-1:0]  rd_data;
  logic           rd_act;
  logic [DW-1:0]  mem [WL];

  // Byte address to word address; bits above the word range cannot exist at this port width.
  assign wa     = WAW'(A_W >> BW);
  assign ra     = WAW'(A_R >> BW);
  assign BUSY   = (state == ST_CLEAR);
  assign rd_act = EN_R & ~BUSY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + WAW'(1);
      if (cnt == WAW'(WL - 1)) state <= ST_IDLE;
    end
  end

  // The sweep owns the write port while busy; user writes are dropped, not deferred.
  always_comb begin
    mem_wa  = wa;
    lane_we = EN_W ? WE : '0;
    wr_data = Di;
    if (BUSY) begin
      mem_wa  = cnt;
      lane_we = '1;
      wr_data = '0;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) mem[mem_wa][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_data = mem[ra];
    if (RDW_MODE == RDW_WRITE_FIRST && EN_W && wa == ra) begin
      for (int i = 0; i < NB; i++)
        rd_data[8*i +: 8] = merge_be(rd_data[8*i +: 8], Di[8*i +: 8], WE[i]);
    end
  end

  bram_rd_pipe #(
    .DW    (DW),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk(CLK),
    .rst(RST),
    .en (rd_act),
    .d  (rd_data),
    .q  (Do),
    .vld(DoVld)
  );

`ifdef BRAM_COLLISION_FLAG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      COLL <= 1'b0;
    end else if (EN_W && (|WE) && EN_R && !BUSY && wa == ra) begin
      COLL <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb/tb_bram_sdp_be.sv - scoreboard bench: read-first/lat1, write-first/lat1 and read-first/lat2 instances
module tb_bram_sdp_be;

  localparam int WL = 1024;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        CLK  = 1'b0;
  logic        RST  = 1'b1;
  logic        EN_W = 1'b0;
  logic        EN_R = 1'b0;
  logic [3:0]  WE   = '0;
  logic [11:0] A_W  = '0;
  logic [11:0] A_R  = '0;
  logic [31:0] Di   = '0;

  logic [31:0] do_rf, do_wf, do_l2;
  logic        vld_rf, vld_wf, vld_l2;
  logic        busy_rf, busy_wf, busy_l2;
`ifdef BRAM_COLLISION_FLAG_EN
  logic        coll_rf, coll_wf, coll_l2;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q_rf[$], q_wf[$], q_l2[$];
  exp_t        e_rf, e_wf, e_l2;
  logic        ev_rf, ev_wf, ev_l2;
  logic [31:0] model [WL];
  logic        model_coll = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  bram_sdp_be #(.RDW_MODE(0), .RD_LAT(1)) u_rf (
    .CLK(CLK), .RST(RST), .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di), .EN_R(EN_R), .A_R(A_R),
    .Do(do_rf), .DoVld(vld_rf), .BUSY(busy_rf)
`ifdef BRAM_COLLISION_FLAG_EN
    , .COLL(coll_rf)
`endif
  );

  bram_sdp_be #(.RDW_MODE(1), .RD_LAT(1)) u_wf (
    .CLK(CLK), .RST(RST), .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di), .EN_R(EN_R), .A_R(A_R),
    .Do(do_wf), .DoVld(vld_wf), .BUSY(busy_wf)
`ifdef BRAM_COLLISION_FLAG_EN
    , .COLL(coll_wf)
`endif
  );

  bram_sdp_be #(.RDW_MODE(0), .RD_LAT(2)) u_l2 (
    .CLK(CLK), .RST(RST), .EN_W(EN_W), .WE(WE), .A_W(A_W), .Di(Di), .EN_R(EN_R), .A_R(A_R),
    .Do(do_l2), .DoVld(vld_l2), .BUSY(busy_l2)
`ifdef BRAM_COLLISION_FLAG_EN
    , .COLL(coll_l2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Output monitors: DoVld must match the scoreboard every cycle; data compared when due.
  always @(negedge CLK) begin
    ev_rf = (q_rf.size() > 0) && (q_rf[0].due == cyc);
    chk("rf_vld", 32'(vld_rf), 32'(ev_rf));
    if (ev_rf) begin
      e_rf = q_rf.pop_front();
      if (vld_rf) chk("rf_data", do_rf, e_rf.data);
    end
  end

  always @(negedge CLK) begin
    ev_wf = (q_wf.size() > 0) && (q_wf[0].due == cyc);
    chk("wf_vld", 32'(vld_wf), 32'(ev_wf));
    if (ev_wf) begin
      e_wf = q_wf.pop_front();
      if (vld_wf) chk("wf_data", do_wf, e_wf.data);
    end
  end

  always @(negedge CLK) begin
    ev_l2 = (q_l2.size() > 0) && (q_l2[0].due == cyc);
    chk("l2_vld", 32'(vld_l2), 32'(ev_l2));
    if (ev_l2) begin
      e_l2 = q_l2.pop_front();
      if (vld_l2) chk("l2_data", do_l2, e_l2.data);
    end
  end

  task automatic drive(input logic ew, input logic [3:0] we, input logic [11:0] aw,
                       input logic [31:0] di, input logic er, input logic [11:0] ar);
    logic [9:0]  wwd, rwd;
    logic [31:0] old, mrg;
    exp_t        e;
    @(negedge CLK);
    EN_W = ew; WE = we; A_W = aw; Di = di; EN_R = er; A_R = ar;
    wwd = aw[11:2];
    rwd = ar[11:2];
    old = model[rwd];
    mrg = old;
    for (int i = 0; i < 4; i++) if (we[i]) mrg[8*i +: 8] = di[8*i +: 8];
    if (er) begin
      e.data = old;                                e.due = cyc + 1; q_rf.push_back(e);
      e.data = (ew && wwd == rwd) ? mrg : old;     e.due = cyc + 1; q_wf.push_back(e);
      e.data = old;                                e.due = cyc + 2; q_l2.push_back(e);
      if (ew && (|we) && wwd == rwd) model_coll = 1'b1;
    end
    if (ew) for (int i = 0; i < 4; i++) if (we[i]) model[wwd][8*i +: 8] = di[8*i +: 8];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; EN_W = 1'b0; EN_R = 1'b0; WE = '0;
    @(posedge CLK);
    #1;
    q_rf.delete(); q_wf.delete(); q_l2.delete();
    for (int i = 0; i < WL; i++) model[i] = '0;
    model_coll = 1'b0;
    @(negedge CLK);
    chk("rst_do", do_rf | do_wf | do_l2, 32'h0);
    chk("rst_vld", {29'd0, vld_rf, vld_wf, vld_l2}, 32'h0);
    chk("rst_busy", {29'd0, busy_rf, busy_wf, busy_l2}, 32'h7);
`ifdef BRAM_COLLISION_FLAG_EN
    chk("rst_coll", {29'd0, coll_rf, coll_wf, coll_l2}, 32'h0);
`endif
    RST = 1'b0;
  endtask

  // Called at the release edge; counts BUSY cycles and pokes a write+read mid-sweep.
  task automatic count_busy(input string tag, input int stop_at);
    int n_rf = 0;
    int n_wf = 0;
    int n_l2 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n == stop_at) return;
      if (!(busy_rf || busy_wf || busy_l2)) break;
      n_rf += int'(busy_rf);
      n_wf += int'(busy_wf);
      n_l2 += int'(busy_l2);
      if (n == 10) begin
        EN_W = 1'b1; WE = 4'hF; A_W = 12'h014; Di = 32'hFFFF_FFFF; EN_R = 1'b1; A_R = 12'h014;
      end else begin
        EN_W = 1'b0; WE = 4'h0; EN_R = 1'b0;
      end
      @(negedge CLK);
    end
    EN_W = 1'b0; WE = 4'h0; EN_R = 1'b0;
    chk({tag, "_rf"}, 32'(n_rf), 32'd1024);
    chk({tag, "_wf"}, 32'(n_wf), 32'd1024);
    chk({tag, "_l2"}, 32'(n_l2), 32'd1024);
  endtask

  initial begin
    do_reset();
    count_busy("sweep0", -1);

    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h01C);
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h014);
    idle(1);
    chk("zero_fill", do_rf, 32'h0);

    drive(1'b1, 4'hF, 12'h010, 32'hAABB_CCDD, 1'b0, 12'h000);
    drive(1'b1, 4'b0010, 12'h010, 32'h0000_1100, 1'b0, 12'h000);
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h010);
    idle(1);
    chk("be_merge", do_rf, 32'hAABB_11DD);

    drive(1'b1, 4'hF, 12'h010, 32'hCAFE_F00D, 1'b0, 12'h000);
    drive(1'b1, 4'hF, 12'h010, 32'h1234_5678, 1'b1, 12'h010);
    idle(1);
    chk("rdw_read_first", do_rf, 32'hCAFE_F00D);
    chk("rdw_write_first", do_wf, 32'h1234_5678);
    idle(1);
    chk("rdw_lat2", do_l2, 32'hCAFE_F00D);
`ifdef BRAM_COLLISION_FLAG_EN
    chk("coll_set", {31'd0, coll_rf}, {31'd0, model_coll});
`endif
    drive(1'b1, 4'b0101, 12'h012, 32'h1122_3344, 1'b1, 12'h013);
    idle(1);
    chk("rdw_partial_wf", do_wf, 32'h1222_5644);

    for (int i = 0; i < 8; i++) drive(1'b1, 4'hF, 12'(i * 4), 32'(i), 1'b0, 12'h000);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'(i * 4));
    idle(2);
    chk("lat2_last", do_l2, 32'd7);

    drive(1'b1, 4'hF, 12'hFFC, 32'h0BAD_BEEF, 1'b0, 12'h000);
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'hFFF);
    idle(1);
    chk("wrap", do_rf, 32'h0BAD_BEEF);
    idle(1);
    chk("vld_off", 32'(vld_rf), 32'd0);
    chk("do_hold", do_rf, 32'h0BAD_BEEF);

    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 4'($urandom), 12'($urandom_range(0, 63)), $urandom,
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)));
    idle(3);
`ifdef BRAM_COLLISION_FLAG_EN
    chk("coll_sticky", {29'd0, coll_rf, coll_wf, coll_l2}, {29'd0, {3{model_coll}}});
`endif

    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h010);
    do_reset();
    count_busy("sweep_abort", 500);
    do_reset();
    count_busy("sweep_restart", -1);

    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h014);
    idle(1);
    chk("sweep_drop", do_rf, 32'h0);
    drive(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h3FC);
    idle(3);
`ifdef BRAM_COLLISION_FLAG_EN
    chk("coll_cleared", {29'd0, coll_rf, coll_wf, coll_l2}, 32'h0);
`endif
    chk("queues_drained", 32'(q_rf.size() + q_wf.size() + q_l2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
